// File: rtl/sdram_scheduler.sv
// SDRAM command scheduler: periodic auto-refresh plus round-robin arbitration of two
// requester ports, each grant becoming one auto-precharged 4-word burst (CL2, BL4).
module sdram_scheduler #(
  parameter int T_RCD            = 1,
  parameter int T_RFC            = 4,
  parameter int T_WRP            = 2,
  parameter int T_RDP            = 1,
  parameter int REFRESH_INTERVAL = 390
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         init_done,
  input  logic [1:0]   req,
  input  logic [1:0]   we,
  input  logic [49:0]  addr,
  input  logic [127:0] wdata,
  output logic [1:0]   ack,
  output logic [15:0]  rdata,
  output logic [1:0]   rvalid,
  output logic         sdram_cs_n,
  output logic         sdram_ras_n,
  output logic         sdram_cas_n,
  output logic         sdram_we_n,
  output logic [12:0]  sdram_addr,
  output logic [1:0]   sdram_ba,
  output logic [15:0]  sdram_dq_out,
  output logic         sdram_dq_oe,
  input  logic [15:0]  sdram_dq_in
);

  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] RFC_LAST = 4'(T_RFC);
  localparam logic [3:0] RCD_LAST = 4'(T_RCD);
  localparam logic [3:0] WR_LAST  = 4'(3 + T_WRP);
  localparam logic [3:0] RD_LAST  = 4'(5 + T_RDP);

  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
  localparam logic [3:0] CMD_READ    = 4'b0101;
  localparam logic [3:0] CMD_WRITE   = 4'b0100;
  localparam logic [3:0] CMD_REFRESH = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_ACTIVE, S_WRITE, S_READ} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          last_grant_q, last_grant_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [24:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   sd_addr_q, sd_addr_d;
  logic [1:0]    ba_q, ba_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic [1:0]    ack_q, ack_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [1:0]    rvalid_q, rvalid_d;

  logic          ref_wrap;
  logic          ref_go;
  logic          pick;
  logic [24:0]   sel_addr;
  logic [12:0]   col_addr;
  logic          unused_col;

  assign ref_wrap   = init_done && (ref_cnt_q == REF_LAST);
  assign ref_go     = (state_q == S_IDLE) && init_done && (ref_pend_q || ref_wrap);
  assign pick       = (req == 2'b11) ? ~last_grant_q : req[1];
  assign sel_addr   = pick ? addr[49:25] : addr[24:0];
  assign col_addr   = {2'b00, 1'b1, addr_q[9:2], 2'b00};
  assign unused_col = ^addr_q[1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_cnt_d    = ref_cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cmd_d        = CMD_NOP;
    sd_addr_d    = sd_addr_q;
    ba_d         = ba_q;
    dq_out_d     = '0;
    dq_oe_d      = 1'b0;
    ack_d        = '0;
    rdata_d      = rdata_q;
    rvalid_d     = '0;

    if (init_done) ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    // A wrap coinciding with the refresh being issued is absorbed by that refresh.
    ref_pend_d = (ref_pend_q || ref_wrap) && !ref_go;

    case (state_q)
      S_IDLE: begin
        if (ref_go) begin
          state_d = S_REFRESH;
          cnt_d   = '0;
          cmd_d   = CMD_REFRESH;
        end else if (init_done && (req != 2'b00)) begin
          state_d      = S_ACTIVE;
          cnt_d        = '0;
          port_d       = pick;
          last_grant_d = pick;
          ack_d        = pick ? 2'b10 : 2'b01;
          we_d         = pick ? we[1] : we[0];
          addr_d       = sel_addr;
          wdata_d      = pick ? wdata[127:64] : wdata[63:0];
          cmd_d        = CMD_ACTIVE;
          ba_d         = sel_addr[24:23];
          sd_addr_d    = sel_addr[22:10];
        end
      end
      S_REFRESH: begin
        if (cnt_q == RFC_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 4'd1;
      end
      S_ACTIVE: begin
        if (cnt_q == RCD_LAST) begin
          state_d   = we_q ? S_WRITE : S_READ;
          cnt_d     = '0;
          cmd_d     = we_q ? CMD_WRITE : CMD_READ;
          sd_addr_d = col_addr;
          ba_d      = addr_q[24:23];
          if (we_q) begin
            dq_oe_d  = 1'b1;
            dq_out_d = wdata_q[15:0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == WR_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 4'd1;
        if (cnt_q < 4'd3) begin
          dq_oe_d = 1'b1;
          case (cnt_q[1:0])
            2'd0:    dq_out_d = wdata_q[31:16];
            2'd1:    dq_out_d = wdata_q[47:32];
            default: dq_out_d = wdata_q[63:48];
          endcase
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) state_d = S_IDLE;
        else cnt_d = cnt_q + 4'd1;
        // CL2 puts word i on the pads two cycles after READ, i.e. at offsets 2..5.
        if ((cnt_q >= 4'd2) && (cnt_q <= 4'd5)) begin
          rdata_d  = sdram_dq_in;
          rvalid_d = port_q ? 2'b10 : 2'b01;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ref_cnt_q    <= '0;
      ref_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cmd_q        <= CMD_NOP;
      sd_addr_q    <= '0;
      ba_q         <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cmd_q        <= cmd_d;
      sd_addr_q    <= sd_addr_d;
      ba_q         <= ba_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_addr   = sd_addr_q;
  assign sdram_ba     = ba_q;
  assign sdram_dq_out = dq_out_q;
  assign sdram_dq_oe  = dq_oe_q;
  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_sdram_scheduler.sv
// Directed testbench for sdram_scheduler: refresh cadence, write/read bursts,
// round-robin fairness, refresh versus traffic and mid-burst reset.
module tb_sdram_scheduler;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] AR  = 4'b0001;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         init_done;
  logic [1:0]   req;
  logic [1:0]   we;
  logic [49:0]  addr;
  logic [127:0] wdata;
  logic [1:0]   ack;
  logic [15:0]  rdata;
  logic [1:0]   rvalid;
  logic         sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0]  sdram_addr;
  logic [1:0]   sdram_ba;
  logic [15:0]  sdram_dq_out;
  logic         sdram_dq_oe;
  logic [15:0]  sdram_dq_in;
  logic [3:0]   cmd;

  int checks = 0;
  int passes = 0;

  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  always #5 clock = ~clock;

  sdram_scheduler dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .rvalid(rvalid),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .sdram_dq_in(sdram_dq_in)
  );

  // One clock step; outputs are then stable and inputs may be changed safely.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 0: the next edge is the first with init_done high.
  task automatic do_reset;
    reset_n = 1'b0; init_done = 1'b0; req = '0; we = '0;
    addr = '0; wdata = '0; sdram_dq_in = '0;
    repeat (2) tick();
    reset_n = 1'b1; init_done = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; init_done = 1'b0; req = '0; we = '0;
    addr = '0; wdata = '0; sdram_dq_in = '0;
    repeat (2) tick();
    checks++; if (cmd !== NOP) $display("[TB] FAIL reset_cmd: got %b expected %b", cmd, NOP); else passes++;
    checks++; if (sdram_addr !== 13'h0) $display("[TB] FAIL reset_addr: got %h expected 0", sdram_addr); else passes++;
    checks++; if (sdram_ba !== 2'b00) $display("[TB] FAIL reset_ba: got %b expected 00", sdram_ba); else passes++;
    checks++; if (sdram_dq_out !== 16'h0) $display("[TB] FAIL reset_dq_out: got %h expected 0", sdram_dq_out); else passes++;
    checks++; if (sdram_dq_oe !== 1'b0) $display("[TB] FAIL reset_dq_oe: got %b expected 0", sdram_dq_oe); else passes++;
    checks++; if (ack !== 2'b00) $display("[TB] FAIL reset_ack: got %b expected 00", ack); else passes++;
    checks++; if (rvalid !== 2'b00) $display("[TB] FAIL reset_rvalid: got %b expected 00", rvalid); else passes++;
    checks++; if (rdata !== 16'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); else passes++;
  endtask

  task automatic test_init_low;
    int bad;
    do_reset();
    init_done = 1'b0; req = 2'b01; we = 2'b01;
    bad = 0;
    repeat (20) begin
      tick();
      if ((ack !== 2'b00) || (cmd !== NOP)) bad++;
    end
    checks++; if (bad !== 0) $display("[TB] FAIL init_low_quiet: got %0d active cycles expected 0", bad); else passes++;
    init_done = 1'b1;
    tick();
    checks++; if (ack !== 2'b01) $display("[TB] FAIL init_high_ack: got %b expected 01", ack); else passes++;
    req = '0;
  endtask

  task automatic test_refresh;
    int n;
    int bad;
    do_reset();
    n = 0;
    for (int i = 1; i <= 500; i++) begin
      tick();
      if (cmd === AR) begin n = i; break; end
    end
    checks++; if (n !== 390) $display("[TB] FAIL first_refresh_cycle: got %0d expected 390", n); else passes++;
    bad = 0;
    repeat (4) begin
      tick();
      if (cmd !== NOP) bad++;
    end
    checks++; if (bad !== 0) $display("[TB] FAIL refresh_nops: got %0d non-NOP expected 0", bad); else passes++;
    n = 4;
    for (int i = 0; i < 500; i++) begin
      tick();
      n++;
      if (cmd === AR) break;
    end
    checks++; if (n !== 390) $display("[TB] FAIL refresh_period: got %0d expected 390", n); else passes++;
  endtask

  task automatic test_write;
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    do_reset();
    tick();
    req = 2'b01; we = 2'b01;
    addr = {25'h1ABCDEF, 2'd2, 13'h155, 10'h3C8};
    wdata = {64'hDEAD_BEEF_0BAD_F00D, 64'h4444_3333_2222_1111};
    tick();
    checks++; if (ack !== 2'b01) $display("[TB] FAIL wr_ack: got %b expected 01", ack); else passes++;
    checks++; if (cmd !== ACT) $display("[TB] FAIL wr_active_cmd: got %b expected %b", cmd, ACT); else passes++;
    checks++; if (sdram_ba !== 2'd2) $display("[TB] FAIL wr_active_ba: got %0d expected 2", sdram_ba); else passes++;
    checks++; if (sdram_addr !== 13'h155) $display("[TB] FAIL wr_active_row: got %h expected 155", sdram_addr); else passes++;
    req = '0;
    tick();
    checks++; if (cmd !== NOP) $display("[TB] FAIL wr_trcd_nop: got %b expected %b", cmd, NOP); else passes++;
    tick();
    checks++; if (cmd !== WR) $display("[TB] FAIL wr_cmd: got %b expected %b", cmd, WR); else passes++;
    checks++; if (sdram_addr !== 13'h7C8) $display("[TB] FAIL wr_col_addr: got %h expected 7c8", sdram_addr); else passes++;
    for (int w = 0; w < 4; w++) begin
      if (w > 0) begin
        tick();
        checks++; if (cmd !== NOP) $display("[TB] FAIL wr_data_nop%0d: got %b expected %b", w, cmd, NOP); else passes++;
      end
      checks++; if (sdram_dq_oe !== 1'b1) $display("[TB] FAIL wr_oe%0d: got %b expected 1", w, sdram_dq_oe); else passes++;
      checks++; if (sdram_dq_out !== words[w]) $display("[TB] FAIL wr_word%0d: got %h expected %h", w, sdram_dq_out, words[w]); else passes++;
    end
    for (int r = 0; r < 2; r++) begin
      tick();
      checks++; if (sdram_dq_oe !== 1'b0) $display("[TB] FAIL wr_recover_oe%0d: got %b expected 0", r, sdram_dq_oe); else passes++;
    end
    // Request raised in the last recovery cycle is only seen from IDLE next cycle.
    req = 2'b10; we = 2'b00;
    tick();
    checks++; if (ack !== 2'b00) $display("[TB] FAIL wr_occupancy_early: got %b expected 00", ack); else passes++;
    tick();
    checks++; if (ack !== 2'b10) $display("[TB] FAIL wr_occupancy_ack: got %b expected 10", ack); else passes++;
    req = '0;
  endtask

  task automatic test_read;
    logic [15:0] words [4];
    logic [1:0]  exp_v;
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
    do_reset();
    tick();
    req = 2'b10; we = 2'b00;
    addr = {2'd1, 13'h0AB, 10'h010, 25'h0};
    tick();
    checks++; if (ack !== 2'b10) $display("[TB] FAIL rd_ack: got %b expected 10", ack); else passes++;
    checks++; if (sdram_ba !== 2'd1) $display("[TB] FAIL rd_ba: got %0d expected 1", sdram_ba); else passes++;
    checks++; if (sdram_addr !== 13'h0AB) $display("[TB] FAIL rd_row: got %h expected 0ab", sdram_addr); else passes++;
    req = '0;
    repeat (2) tick();
    checks++; if (cmd !== RD) $display("[TB] FAIL rd_cmd: got %b expected %b", cmd, RD); else passes++;
    checks++; if (sdram_addr !== 13'h410) $display("[TB] FAIL rd_col_addr: got %h expected 410", sdram_addr); else passes++;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_v = ((j >= 3) && (j <= 6)) ? 2'b10 : 2'b00;
      checks++; if (rvalid !== exp_v) $display("[TB] FAIL rd_rvalid_k%0d: got %b expected %b", j, rvalid, exp_v); else passes++;
      if ((j >= 3) && (j <= 6)) begin
        checks++; if (rdata !== words[j-3]) $display("[TB] FAIL rd_rdata_k%0d: got %h expected %h", j, rdata, words[j-3]); else passes++;
      end
      sdram_dq_in = ((j >= 2) && (j <= 5)) ? words[j-2] : 16'h0000;
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] got [4];
    logic [1:0] exp_seq [4];
    int n;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    do_reset();
    tick();
    req = 2'b11; we = 2'b11;
    addr = {2'd3, 13'h001, 10'h004, 2'd0, 13'h002, 10'h008};
    wdata = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ((ack !== 2'b00) && (n < 4)) begin got[n] = ack; n++; end
      if (n == 4) break;
    end
    checks++; if (n !== 4) $display("[TB] FAIL rr_ack_count: got %0d expected 4", n); else passes++;
    for (int g = 0; g < 4; g++) begin
      if (g < n) begin
        checks++; if (got[g] !== exp_seq[g]) $display("[TB] FAIL rr_grant%0d: got %b expected %b", g, got[g], exp_seq[g]); else passes++;
      end
    end
    req = '0;
  endtask

  task automatic test_refresh_during_read;
    logic [15:0] words [4];
    logic [1:0]  exp_v;
    logic [3:0]  exp_c;
    words[0] = 16'h5A5A; words[1] = 16'hA5A5; words[2] = 16'h0F0F; words[3] = 16'hF0F0;
    do_reset();
    repeat (384) tick();
    req = 2'b10; we = 2'b00;
    addr = {2'd0, 13'h1FFF, 10'h3FC, 25'h0};
    tick();
    checks++; if (cmd !== ACT) $display("[TB] FAIL rfrd_active: got %b expected %b", cmd, ACT); else passes++;
    req = '0;
    repeat (2) tick();
    checks++; if (cmd !== RD) $display("[TB] FAIL rfrd_read: got %b expected %b", cmd, RD); else passes++;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_v = ((j >= 3) && (j <= 6)) ? 2'b10 : 2'b00;
      exp_c = (j == 8) ? AR : NOP;
      checks++; if (rvalid !== exp_v) $display("[TB] FAIL rfrd_rvalid_k%0d: got %b expected %b", j, rvalid, exp_v); else passes++;
      if ((j >= 3) && (j <= 6)) begin
        checks++; if (rdata !== words[j-3]) $display("[TB] FAIL rfrd_rdata_k%0d: got %h expected %h", j, rdata, words[j-3]); else passes++;
      end
      checks++; if (cmd !== exp_c) $display("[TB] FAIL rfrd_cmd_k%0d: got %b expected %b", j, cmd, exp_c); else passes++;
      sdram_dq_in = ((j >= 2) && (j <= 5)) ? words[j-2] : 16'h0000;
    end
  endtask

  task automatic test_refresh_vs_req;
    int m;
    do_reset();
    repeat (389) tick();
    req = 2'b01; we = 2'b01;
    tick();
    checks++; if (cmd !== AR) $display("[TB] FAIL tie_refresh_cmd: got %b expected %b", cmd, AR); else passes++;
    checks++; if (ack !== 2'b00) $display("[TB] FAIL tie_no_ack: got %b expected 00", ack); else passes++;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      m++;
      if (ack !== 2'b00) break;
    end
    checks++; if (m !== 6) $display("[TB] FAIL tie_ack_delay: got %0d expected 6", m); else passes++;
    checks++; if (ack !== 2'b01) $display("[TB] FAIL tie_ack_port: got %b expected 01", ack); else passes++;
    req = '0;
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    tick();
    req = 2'b01; we = 2'b01;
    addr = {25'h0, 2'd1, 13'h0F0, 10'h100};
    wdata = {64'h0, 64'hBEEF_CAFE_F00D_1234};
    tick();
    req = '0;
    repeat (3) tick();
    checks++; if (sdram_dq_oe !== 1'b1) $display("[TB] FAIL mid_oe_before: got %b expected 1", sdram_dq_oe); else passes++;
    reset_n = 1'b0;
    tick();
    checks++; if (sdram_dq_oe !== 1'b0) $display("[TB] FAIL mid_reset_oe: got %b expected 0", sdram_dq_oe); else passes++;
    checks++; if (cmd !== NOP) $display("[TB] FAIL mid_reset_cmd: got %b expected %b", cmd, NOP); else passes++;
    checks++; if (ack !== 2'b00) $display("[TB] FAIL mid_reset_ack: got %b expected 00", ack); else passes++;
    checks++; if (sdram_dq_out !== 16'h0) $display("[TB] FAIL mid_reset_dq: got %h expected 0", sdram_dq_out); else passes++;
    reset_n = 1'b1;
    req = 2'b10; we = 2'b00;
    tick();
    checks++; if (ack !== 2'b10) $display("[TB] FAIL mid_reset_idle_ack: got %b expected 10", ack); else passes++;
    checks++; if (cmd !== ACT) $display("[TB] FAIL mid_reset_idle_cmd: got %b expected %b", cmd, ACT); else passes++;
    req = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; init_done = 1'b0; req = '0; we = '0;
    addr = '0; wdata = '0; sdram_dq_in = '0;
    test_reset();
    test_init_low();
    test_refresh();
    test_write();
    test_read();
    test_back_to_back();
    test_refresh_during_read();
    test_refresh_vs_req();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
